// File: rtl/vram_arb_pkg.sv
// Shared constants and state encodings for the VRAM port-B arbiter and its fill engine.
package vram_arb_pkg;

    localparam int FIELD_W = 10;

    localparam logic [11:0] CTRL_ADDR  = 12'hA00;
    localparam logic [11:0] BASE_ADDR  = 12'hA01;
    localparam logic [11:0] COUNT_ADDR = 12'hA02;
    localparam logic [11:0] FILL_ADDR  = 12'hA03;

    localparam int CTRL_START = 0;
    localparam int CTRL_BUSY  = 1;
    localparam int CTRL_DONE  = 2;

    typedef enum logic {CPU_IDLE, CPU_RD_WAIT} cpu_state_t;
    typedef enum logic {FILL_IDLE, FILL_RUN} fill_state_t;

endpackage

// File: rtl/fill_engine.sv
// Constant-word fill over a wrapping VRAM range; one word per granted cycle.
// Requests port B whenever running and simply holds its pointer while not granted.
module fill_engine
    import vram_arb_pkg::*;
#(
    parameter int VRAM_WORDS = 600
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               clr_done,
    input  logic               gnt,
    input  logic [FIELD_W-1:0] base,
    input  logic [FIELD_W-1:0] count,
    input  logic [31:0]        fill,
    output logic               req,
    output logic               done,
    output logic [FIELD_W-1:0] wr_addr,
    output logic [31:0]        wr_data
);
    localparam logic [FIELD_W-1:0] WORDS = FIELD_W'(VRAM_WORDS);
    localparam logic [FIELD_W-1:0] LAST  = FIELD_W'(VRAM_WORDS - 1);

    fill_state_t        state;
    logic [FIELD_W-1:0] ptr;
    logic [FIELD_W-1:0] remaining;
    logic [FIELD_W-1:0] eff_count;
    logic [FIELD_W-1:0] eff_base;
    logic               done_set;

    // Out-of-range setup is clamped rather than rejected so software always gets a DONE.
    assign eff_count = (count > WORDS) ? WORDS : count;
    assign eff_base  = (base >= WORDS) ? '0 : base;

    assign done_set = ((state == FILL_IDLE) && start && (eff_count == '0)) ||
                      ((state == FILL_RUN) && gnt && (remaining == FIELD_W'(1)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= FILL_IDLE;
            ptr       <= '0;
            remaining <= '0;
            done      <= 1'b0;
        end else begin
            done <= done_set | (done & ~clr_done);
            if (state == FILL_IDLE) begin
                if (start && (eff_count != '0)) begin
                    ptr       <= eff_base;
                    remaining <= eff_count;
                    state     <= FILL_RUN;
                end
            end else if (gnt) begin
                ptr       <= (ptr == LAST) ? '0 : ptr + 1'b1;
                remaining <= remaining - 1'b1;
                if (remaining == FIELD_W'(1)) begin
                    state <= FILL_IDLE;
                end
            end
        end
    end

    assign req     = (state == FILL_RUN);
    assign wr_addr = ptr;
    assign wr_data = fill;

endmodule

// File: rtl/vram_fill_arbiter.sv
// Shares VRAM port B between Avalon CPU accesses and the fill engine; CPU has priority
// unless the engine has been starved STARVE_MAX cycles. Writes are zero-wait, reads take one wait state.
module vram_fill_arbiter
    import vram_arb_pkg::*;
#(
    parameter int ADDR_W     = 12,
    parameter int VRAM_WORDS = 600,
    parameter int STARVE_MAX = 4
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              AVL_CS,
    input  logic              AVL_READ,
    input  logic              AVL_WRITE,
    input  logic [ADDR_W-1:0] AVL_ADDR,
    input  logic [3:0]        AVL_BYTE_EN,
    input  logic [31:0]       AVL_WRITEDATA,
    output logic [31:0]       AVL_READDATA,
    output logic              AVL_WAITREQUEST,
    output logic [ADDR_W-1:0] RAM_ADDR,
    output logic [3:0]        RAM_BYTE_EN,
    output logic [31:0]       RAM_WDATA,
    output logic              RAM_WREN,
    output logic              RAM_RDEN,
    input  logic [31:0]       RAM_Q,
    output logic              FILL_DONE_IRQ
);
    localparam int SW = $clog2(STARVE_MAX + 1);

    cpu_state_t         cpu_state;
    logic [SW-1:0]      starve;
    logic [FIELD_W-1:0] base;
    logic [FIELD_W-1:0] count;
    logic [31:0]        fill;
    logic [31:0]        rd_hold;
    logic [31:0]        reg_val;
    logic [31:0]        eng_data;
    logic [FIELD_W-1:0] eng_addr;
    logic               rd_from_ram;
    logic               eng_req, eng_gnt, cpu_req, cpu_gnt, done;
    logic               cpu_idle, is_vram, is_ctrl, is_base, is_count, is_fill;
    logic               reg_wr, reg_rd, start, clr_done;

    assign cpu_idle = (cpu_state == CPU_IDLE);
    assign is_vram  = (AVL_ADDR < ADDR_W'(VRAM_WORDS));
    assign is_ctrl  = (AVL_ADDR == ADDR_W'(CTRL_ADDR));
    assign is_base  = (AVL_ADDR == ADDR_W'(BASE_ADDR));
    assign is_count = (AVL_ADDR == ADDR_W'(COUNT_ADDR));
    assign is_fill  = (AVL_ADDR == ADDR_W'(FILL_ADDR));

    // While a read is completing the CPU holds its strobe, so it must not re-request the port.
    assign cpu_req = cpu_idle & AVL_CS & (AVL_READ | AVL_WRITE) & is_vram;
    assign eng_gnt = eng_req & (~cpu_req | (starve == SW'(STARVE_MAX)));
    assign cpu_gnt = cpu_req & ~eng_gnt;

    assign reg_wr   = cpu_idle & AVL_CS & AVL_WRITE & ~is_vram;
    assign reg_rd   = cpu_idle & AVL_CS & AVL_READ & ~AVL_WRITE & ~is_vram;
    assign start    = reg_wr & is_ctrl & AVL_WRITEDATA[CTRL_START];
    assign clr_done = reg_wr & is_ctrl & AVL_WRITEDATA[CTRL_DONE];

    always_comb begin
        reg_val = '0;
        if (is_ctrl) begin
            reg_val[CTRL_BUSY] = eng_req;
            reg_val[CTRL_DONE] = done;
        end else if (is_base) begin
            reg_val[FIELD_W-1:0] = base;
        end else if (is_count) begin
            reg_val[FIELD_W-1:0] = count;
        end else if (is_fill) begin
            reg_val = fill;
        end
    end

    fill_engine #(
        .VRAM_WORDS(VRAM_WORDS)
    ) u_fill (
        .clk      (CLK),
        .rst      (RESET),
        .start    (start),
        .clr_done (clr_done),
        .gnt      (eng_gnt),
        .base     (base),
        .count    (count),
        .fill     (fill),
        .req      (eng_req),
        .done     (done),
        .wr_addr  (eng_addr),
        .wr_data  (eng_data)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cpu_state   <= CPU_IDLE;
            rd_from_ram <= 1'b0;
            rd_hold     <= '0;
            starve      <= '0;
            base        <= '0;
            count       <= '0;
            fill        <= '0;
        end else begin
            starve <= (!eng_req || eng_gnt) ? '0 : starve + 1'b1;
            if (reg_wr && !eng_req) begin
                if (is_base)  base  <= AVL_WRITEDATA[FIELD_W-1:0];
                if (is_count) count <= AVL_WRITEDATA[FIELD_W-1:0];
                if (is_fill)  fill  <= AVL_WRITEDATA;
            end
            if (!cpu_idle) begin
                cpu_state <= CPU_IDLE;
            end else if (reg_rd) begin
                cpu_state   <= CPU_RD_WAIT;
                rd_from_ram <= 1'b0;
                rd_hold     <= reg_val;
            end else if (cpu_gnt && !AVL_WRITE) begin
                cpu_state   <= CPU_RD_WAIT;
                rd_from_ram <= 1'b1;
            end
        end
    end

    assign AVL_WAITREQUEST = cpu_idle & ~reg_wr & ~(cpu_gnt & AVL_WRITE);
    assign AVL_READDATA    = cpu_idle ? '0 : (rd_from_ram ? RAM_Q : rd_hold);

    assign RAM_WREN    = eng_gnt | (cpu_gnt & AVL_WRITE);
    assign RAM_RDEN    = cpu_gnt & ~AVL_WRITE;
    assign RAM_ADDR    = eng_gnt ? ADDR_W'(eng_addr) : AVL_ADDR;
    assign RAM_BYTE_EN = eng_gnt ? 4'hF : AVL_BYTE_EN;
    assign RAM_WDATA   = eng_gnt ? eng_data : AVL_WRITEDATA;

    assign FILL_DONE_IRQ = done;

endmodule

// File: doc/vram_fill_arbiter.md
Name: vram_fill_arbiter

Overview:
- Owns VRAM port B. Port A stays dedicated to VGA scanout.
- Shares port B between Avalon-MM CPU accesses and an internal hardware fill engine. The fill engine writes a constant word over a VRAM range, for screen clear and row blanking.
- Sits between the Avalon slave and the dual-port VRAM; the palette register block is outside it.
- Exposes engine control registers and a done interrupt.

Parameters:
- ADDR_W, 12, Avalon/VRAM word-address width.
- VRAM_WORDS, 600, number of valid VRAM words (80x30 chars, 4 per word).
- STARVE_MAX, 4, consecutive engine-blocked cycles before the engine is forced a slot.

Ports:
- CLK  in  1  system clock (50 MHz)
- RESET  in  1  reset, asynchronous, active-high
- AVL_CS  in  1  chip select
- AVL_READ  in  1  read strobe
- AVL_WRITE  in  1  write strobe
- AVL_ADDR  in  ADDR_W  word address
- AVL_BYTE_EN  in  4  byte enables
- AVL_WRITEDATA  in  32  write data
- AVL_READDATA  out  32  read data, valid when waitrequest low on a read
- AVL_WAITREQUEST  out  1  stall
- RAM_ADDR  out  ADDR_W  port-B address
- RAM_BYTE_EN  out  4  port-B byte enables
- RAM_WDATA  out  32  port-B write data
- RAM_WREN  out  1  port-B write enable
- RAM_RDEN  out  1  port-B read enable
- RAM_Q  in  32  port-B read data, 1-cycle latency
- FILL_DONE_IRQ  out  1  level, equals DONE flag

Behaviour:
- Clock and reset: one clock, CLK. RESET is asynchronous, active-high.
- Reset values: all state IDLE; AVL_READDATA=0; RAM_WREN=RAM_RDEN=0; AVL_WAITREQUEST=1; FILL_DONE_IRQ=0; registers BASE, COUNT, FILL, DONE, BUSY, ptr, remaining and starve counter all 0.
- Address map:
  - 0..VRAM_WORDS-1: VRAM.
  - 0xA00 CTRL: bit0 START (write 1 to start, reads 0); bit1 BUSY (read-only); bit2 DONE (sticky, write 1 to clear).
  - 0xA01 BASE[9:0].
  - 0xA02 COUNT[9:0].
  - 0xA03 FILL[31:0].
  - Any other address: writes ignored, reads return 0.
  - Register byte enables are ignored; full-word access only.
- Port B carries one operation per cycle. Requesters:
  - CPU: AVL_CS & (READ|WRITE) to VRAM.
  - Engine: BUSY.
- Grant rule:
  - CPU wins, unless starve==STARVE_MAX, in which case the engine wins.
  - starve increments each cycle the engine is requesting and loses. It resets to 0 on an engine grant or when the engine is idle.
- CPU write to VRAM:
  - On the granted cycle: RAM_WREN=1, RAM_ADDR=AVL_ADDR, RAM_BYTE_EN=AVL_BYTE_EN, RAM_WDATA=AVL_WRITEDATA (combinational), AVL_WAITREQUEST=0. This is zero-wait.
  - Not granted: waitrequest stays 1.
- CPU read (VRAM or register):
  - CPU FSM is IDLE -> RD_WAIT -> IDLE.
  - VRAM read, granted cycle: RAM_RDEN=1, waitrequest=1, go to RD_WAIT.
  - RD_WAIT: AVL_READDATA=RAM_Q, or the register value captured on the previous edge; waitrequest=0; return to IDLE.
  - Register reads take the same 2 cycles but use no RAM slot.
  - Port B is free to the engine during RD_WAIT.
  - Total read latency is 1 wait state when uncontended.
- Register writes: zero-wait, never stalled.
- Engine FSM, IDLE -> RUN -> IDLE:
  - START while IDLE:
    - Effective COUNT = min(COUNT, VRAM_WORDS).
    - Effective BASE = 0 if BASE >= VRAM_WORDS.
    - If effective COUNT==0: set DONE on the next edge, no writes.
    - Otherwise: ptr=BASE, remaining=COUNT, BUSY=1, go to RUN.
  - RUN, each engine-granted cycle:
    - RAM_WREN=1, RAM_ADDR=ptr, RAM_BYTE_EN=4'hF, RAM_WDATA=FILL.
    - ptr wraps from VRAM_WORDS-1 to 0.
    - remaining decrements.
  - When remaining reaches 0 (after the last write): BUSY=0, DONE=1, go to IDLE.
- Boundary conditions:
  - START while BUSY: ignored.
  - Writes to BASE, COUNT or FILL while BUSY: ignored.
  - DONE set and W1C on the same cycle: set wins.
  - CPU VRAM write to the same address as the engine's write: whichever is granted later determines final content.
  - RESET asserted mid-fill: the engine aborts immediately; DONE stays 0.
  - CPU AVL_READ and AVL_WRITE both high: treated as a write.

Decomposition:
- Package vram_arb_pkg:
  - Address constants CTRL_ADDR=0xA00, BASE_ADDR, COUNT_ADDR, FILL_ADDR.
  - CTRL bit indices.
  - Enum cpu_state_t {CPU_IDLE, CPU_RD_WAIT}.
  - Enum fill_state_t {FILL_IDLE, FILL_RUN}.
- Sub-module fill_engine: holds ptr/remaining/BUSY/DONE and the FSM. Interface: req, gnt, wr address/data.
- Top level holds the arbiter, the starve counter, the CPU FSM and register decode.

Test Plan:
- Idle CPU: BASE=0, COUNT=600, FILL=0x20202020, START -> exactly 600 engine writes on 600 consecutive cycles, addresses 0..599; DONE=1 and IRQ=1 the cycle after the last write.
- Wrap: BASE=598, COUNT=4 -> writes to 598, 599, 0, 1, then DONE; VRAM word 2 unchanged.
- Contention with STARVE_MAX=4: fill running while CPU writes back-to-back to address 10 -> pattern of 4 CPU grants then 1 engine grant. The 5th CPU write sees waitrequest=1 for one cycle. Fill completes.
- CPU read of VRAM[5]=0xDEADBEEF -> RAM_RDEN on cycle 0, AVL_READDATA=0xDEADBEEF with waitrequest=0 on cycle 1. The engine gets a write slot on cycle 1.
- Edge controls: COUNT=0 START -> no RAM_WREN, DONE=1 next cycle. START while BUSY -> no restart. W1C of CTRL bit2 -> IRQ deasserts.
- Assert RESET mid-fill after 3 writes -> RAM_WREN=0 immediately (async); BUSY=0, DONE=0; no further writes after release.
